// File: rtl/imu_rd_seq.sv
// imu_rd_seq: power-up, init and frame-read sequencer for an SPI IMU.
// Optional spi_done watchdog: define IMU_TIMEOUT_EN.
module imu_rd_seq #(
    parameter int                    NUM_CH    = 5,
    parameter int                    INIT_N    = 4,
    parameter logic [INIT_N*16-1:0]  INIT_CMDS = {16'h1460, 16'h1162,
                                                  16'h1062, 16'h0D02},
    parameter logic [6:0]            RD_BASE   = 7'h22,
    parameter int                    STARTUP_W = 16,
    parameter int                    TMO_CYC   = 4095
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  INT,
    input  logic                  poll_mode,
    input  logic [15:0]           poll_div,
    output logic                  spi_wrt,
    output logic [15:0]           spi_cmd,
    input  logic                  spi_done,
    input  logic [15:0]           spi_rd,
    output logic [NUM_CH*16-1:0]  data,
    output logic                  vld,
    output logic                  busy,
    output logic                  tmo_err
);

    localparam int IW = (INIT_N > 1) ? $clog2(INIT_N) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_N - 1);
    localparam logic [3:0] RD_LAST = 4'(2 * NUM_CH - 1);
    // Write goes out on the edge where the counter becomes all-ones.
    localparam logic [STARTUP_W-1:0] ST_LAST =
        {{(STARTUP_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_STARTUP,
        S_INIT,
        S_IDLE,
        S_READ,
        S_VALID
    } state_t;

    state_t                 state;
    logic                   int1;
    logic                   int2;
    logic [STARTUP_W-1:0]   st_cnt;
    logic [IW-1:0]          init_idx;
    logic [3:0]             rd_idx;
    logic [15:0]            poll_cnt;
    logic [NUM_CH*16-1:0]   shadow;
    logic [15:0]            pdiv;
    logic                   poll_hit;
    logic                   trigger;

    function automatic logic [15:0] rd_cmd(input logic [3:0] k);
        return {1'b1, RD_BASE + {3'b000, k}, 8'h00};
    endfunction

    function automatic logic [15:0] init_cmd(input logic [IW-1:0] i);
        return INIT_CMDS[16*i +: 16];
    endfunction

    assign pdiv     = (poll_div == 16'd0) ? 16'd1 : poll_div;
    assign poll_hit = (poll_cnt >= pdiv);
    assign trigger  = poll_mode ? poll_hit : int2;

`ifdef IMU_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    // Cycles since the last write while a transaction is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == S_INIT || state == S_READ) && !spi_done) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end
`else
    assign tmo_err = 1'b0;
`endif

    // Two-flop synchronizer for the asynchronous data-ready line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int1 <= 1'b0;
            int2 <= 1'b0;
        end else begin
            int1 <= INT;
            int2 <= int1;
        end
    end

    // Poll timer: only runs while idling in poll mode, clears on a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= 16'd0;
        end else if (!poll_mode || state != S_IDLE || poll_hit) begin
            poll_cnt <= 16'd0;
        end else begin
            poll_cnt <= poll_cnt + 16'd1;
        end
    end

    // Sequencer FSM with registered SPI strobe, data, vld and busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_STARTUP;
            st_cnt   <= '0;
            init_idx <= '0;
            rd_idx   <= 4'd0;
            shadow   <= '0;
            data     <= '0;
            vld      <= 1'b0;
            spi_wrt  <= 1'b0;
            spi_cmd  <= 16'h0000;
            busy     <= 1'b1;
`ifdef IMU_TIMEOUT_EN
            tmo_err  <= 1'b0;
`endif
        end else begin
            spi_wrt <= 1'b0;
            vld     <= 1'b0;
            unique case (state)
                S_STARTUP: begin
                    st_cnt <= st_cnt + 1'b1;
                    if (st_cnt == ST_LAST) begin
                        spi_wrt  <= 1'b1;
                        spi_cmd  <= init_cmd('0);
                        init_idx <= '0;
                        state    <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (spi_done) begin
                        if (init_idx == INIT_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            init_idx <= init_idx + 1'b1;
                            spi_wrt  <= 1'b1;
                            spi_cmd  <= init_cmd(init_idx + 1'b1);
                        end
                    end
`ifdef IMU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tmo_err <= 1'b1;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end
`endif
                end
                S_IDLE: begin
                    if (trigger) begin
                        rd_idx  <= 4'd0;
                        spi_wrt <= 1'b1;
                        spi_cmd <= rd_cmd(4'd0);
                        state   <= S_READ;
                        busy    <= 1'b1;
                    end
                end
                S_READ: begin
                    if (spi_done) begin
                        shadow[8*rd_idx +: 8] <= spi_rd[7:0];
                        if (rd_idx == RD_LAST) begin
                            state <= S_VALID;
                        end else begin
                            rd_idx  <= rd_idx + 4'd1;
                            spi_wrt <= 1'b1;
                            spi_cmd <= rd_cmd(rd_idx + 4'd1);
                        end
                    end
`ifdef IMU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        tmo_err <= 1'b1;
                        shadow  <= '0;
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                    end
`endif
                end
                S_VALID: begin
                    data  <= shadow;
                    vld   <= 1'b1;
                    state <= S_IDLE;
                    busy  <= 1'b0;
`ifdef IMU_TIMEOUT_EN
                    tmo_err <= 1'b0;
`endif
                end
                default: begin
                    state <= S_STARTUP;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imu_rd_seq.sv
// tb_imu_rd_seq: directed bench for imu_rd_seq with a behavioural
// SPI slave that answers each write after a programmable delay.
module tb_imu_rd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        INT;
    logic        poll_mode;
    logic [15:0] poll_div;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd;
    logic [79:0] data;
    logic        vld;
    logic        busy;
    logic        tmo_err;

    imu_rd_seq #(
        .STARTUP_W (4),
        .TMO_CYC   (50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .INT       (INT),
        .poll_mode (poll_mode),
        .poll_div  (poll_div),
        .spi_wrt   (spi_wrt),
        .spi_cmd   (spi_cmd),
        .spi_done  (spi_done),
        .spi_rd    (spi_rd),
        .data      (data),
        .vld       (vld),
        .busy      (busy),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          dly     = 20;
    int          drop_k  = -1;
    int          vld_cnt = 0;
    logic [7:0]  byte_base = 8'h01;
    logic [15:0] cmd_log[$];
    int          cmd_cyc[$];
    int          starts[$];
    logic [15:0] init_exp [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [79:0] got,
                         input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI slave: logs each write, answers dly cycles later.
    initial begin
        int          cd;
        int          k;
        logic [15:0] pend;
        cd       = 0;
        pend     = 16'h0;
        spi_done = 1'b0;
        spi_rd   = 16'h0;
        forever begin
            @(negedge clk);
            spi_done = 1'b0;
            if (vld) vld_cnt++;
            if (!rst_n) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        spi_done = 1'b1;
                        spi_rd   = pend;
                    end
                end
                if (spi_wrt) begin
                    cmd_log.push_back(spi_cmd);
                    cmd_cyc.push_back(cyc);
                    if (spi_cmd == 16'hA200) starts.push_back(cyc);
                    k    = int'(spi_cmd[14:8]) - 'h22;
                    pend = {8'hEE, byte_base + 8'(k)};
                    if (spi_cmd[15] && k == drop_k) begin
                        drop_k = -1;
                        cd     = 0;
                    end else begin
                        cd = dly - 1;
                    end
                end
            end
        end
    end

    task automatic int_pulse(input int n);
        INT = 1'b1;
        repeat (n) @(negedge clk);
        INT = 1'b0;
    endtask

    task automatic wait_vld(input string tag, input int max);
        for (int i = 0; i < max && vld_cnt == 0; i++) @(negedge clk);
        check(tag, vld_cnt != 0, 1'b1);
    endtask

    task automatic startup_seq(input string tag);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_log.delete();
        cmd_cyc.delete();
        repeat (14) @(negedge clk);
        check({tag, "_pre_wrt"}, spi_wrt, 1'b0);
        @(negedge clk);
        check({tag, "_wrt_c15"}, spi_wrt, 1'b1);
        check({tag, "_cmd0"}, spi_cmd, 16'h0D02);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_ncmd"}, cmd_log.size(), 4);
        for (int i = 1; i < 4; i++)
            check({tag, "_cmd"},
                  (i < cmd_log.size()) ? cmd_log[i] : 16'hxxxx,
                  init_exp[i]);
    endtask

    initial begin
        logic [79:0] f1;
        logic [79:0] f2;
        logic [79:0] f3;
        f1 = 80'h0A09_0807_0605_0403_0201;
        f2 = 80'h1A19_1817_1615_1413_1211;
        f3 = 80'h3A39_3837_3635_3433_3231;

        rst_n     = 1'b0;
        INT       = 1'b0;
        poll_mode = 1'b0;
        poll_div  = 16'd100;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b1);
        check("rst_vld", vld, 1'b0);
        check("rst_wrt", spi_wrt, 1'b0);
        check("rst_cmd", spi_cmd, 16'h0);
        check("rst_data", data, 80'h0);
        check("rst_tmo", tmo_err, 1'b0);

        startup_seq("init");

        // INT-triggered frame
        dly       = 3;
        byte_base = 8'h01;
        cmd_log.delete();
        vld_cnt   = 0;
        int_pulse(3);
        wait_vld("f1_done", 300);
        repeat (5) @(negedge clk);
        check("f1_ncmd", cmd_log.size(), 10);
        for (int k = 0; k < 10; k++)
            check("f1_cmd", (k < cmd_log.size()) ? cmd_log[k] : 16'hxxxx,
                  16'hA200 + 16'(k << 8));
        check("f1_ch0", data[15:0], 16'h0201);
        check("f1_ch4", data[79:64], 16'h0A09);
        check("f1_data", data, f1);
        check("f1_nvld", vld_cnt, 1);
        check("f1_busy", busy, 1'b0);

        // Second INT pulse mid-frame is ignored
        byte_base = 8'h11;
        cmd_log.delete();
        vld_cnt   = 0;
        int_pulse(2);
        repeat (10) @(negedge clk);
        int_pulse(2);
        check("f2_mid_data", data, f1);
        wait_vld("f2_done", 300);
        repeat (40) @(negedge clk);
        check("f2_nvld", vld_cnt, 1);
        check("f2_ncmd", cmd_log.size(), 10);
        check("f2_data", data, f2);

        // Poll mode off: no frames without INT
        vld_cnt = 0;
        repeat (300) @(negedge clk);
        check("nopoll_vld", vld_cnt, 0);

        // Poll period: poll_div + 1 idle counts + 10*dly read + 1 valid
        starts.delete();
        poll_div  = 16'd100;
        poll_mode = 1'b1;
        for (int i = 0; i < 800 && starts.size() < 3; i++)
            @(negedge clk);
        check("poll100_gap",
              (starts.size() >= 3) ? starts[2] - starts[1] : -1,
              100 + 10 * 3 + 2);
        check("poll100_vld", vld_cnt >= 2, 1'b1);

        poll_div = 16'd0;
        starts.delete();
        for (int i = 0; i < 300 && starts.size() < 3; i++)
            @(negedge clk);
        check("poll0_gap",
              (starts.size() >= 3) ? starts[2] - starts[1] : -1,
              1 + 10 * 3 + 2);
        poll_mode = 1'b0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("poll_off_busy", busy, 1'b0);
        check("poll_data", data, f2);

`ifdef IMU_TIMEOUT_EN
        begin
            int t_err;
            vld_cnt   = 0;
            cmd_log.delete();
            cmd_cyc.delete();
            drop_k    = 3;
            byte_base = 8'h21;
            int_pulse(2);
            t_err = -1;
            for (int i = 0; i < 300 && !tmo_err; i++) @(negedge clk);
            if (tmo_err) t_err = cyc;
            check("tmo_set", tmo_err, 1'b1);
            check("tmo_delay",
                  (cmd_cyc.size() >= 4) ? t_err - cmd_cyc[3] : -1, 50);
            repeat (2) @(negedge clk);
            check("tmo_idle", busy, 1'b0);
            check("tmo_novld", vld_cnt, 0);
            check("tmo_data", data, f2);
            byte_base = 8'h31;
            int_pulse(2);
            wait_vld("tmo_rec_done", 300);
            check("tmo_clear", tmo_err, 1'b0);
            check("tmo_rec_data", data, f3);
        end
`else
        check("tmo_tied", tmo_err, 1'b0);
        check("f3_unused", f3 == f2, 1'b0);
`endif

        // Reset during transaction 4
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        vld_cnt   = 0;
        cmd_log.delete();
        byte_base = 8'h41;
        int_pulse(2);
        for (int i = 0; i < 100 && cmd_log.size() < 5; i++)
            @(negedge clk);
        check("mid_wrt_k4", spi_cmd, 16'hA600);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b1);
        check("arst_wrt", spi_wrt, 1'b0);
        check("arst_cmd", spi_cmd, 16'h0);
        check("arst_data", data, 80'h0);
        check("arst_vld", vld, 1'b0);
        @(negedge clk);
        startup_seq("reinit");
        check("arst_novld", vld_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imu_rd_seq.md
IMU_RD_SEQ -- requirements
Module: imu_rd_seq

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_CH, 5: number of 16-bit sensor channels read per frame (1..8).
- INIT_N, 4: number of init commands.
- INIT_CMDS, {16'h1460,16'h1162,16'h1062,16'h0D02}: packed INIT_N*16 commands; element i is bits [16i+15:16i], issued i=0 first.
- RD_BASE, 7'h22: register address of channel 0 low byte.
- STARTUP_W, 16: width of the power-up delay counter.
- TMO_CYC, 4095: spi_done timeout in cycles; used only with IMU_TIMEOUT_EN.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- INT, in, 1: sensor data-ready, asynchronous to clk.
- poll_mode, in, 1: 0 = frame on INT, 1 = frame on poll timer.
- poll_div, in, 16: poll period in cycles.
- spi_wrt, out, 1: one-cycle transaction start to the SPI master.
- spi_cmd, out, 16: command word, valid while spi_wrt=1.
- spi_done, in, 1: one-cycle end of transaction.
- spi_rd, in, 16: read data, valid with spi_done; byte in [7:0].
- data, out, NUM_CH*16: channel c at [16c+15:16c], signed.
- vld, out, 1: one-cycle pulse when data updates.
- busy, out, 1: high outside IDLE.
- tmo_err, out, 1: sticky timeout flag.

Function
REQ-003 INT SHALL be double-flopped; only the synchronized INT2 is used.
REQ-004 The states SHALL be STARTUP, INIT, IDLE, READ and VALID.
REQ-005 STARTUP: a STARTUP_W-bit counter increments from 0; when it reaches all-ones, the block asserts spi_wrt with INIT_CMDS[0] and goes to INIT.
REQ-006 INIT: on each spi_done, the block issues the next init command in the same cycle; on spi_done of the last command it goes to IDLE without a write.
REQ-007 Transaction k (0..2*NUM_CH-1) SHALL use spi_cmd = {1'b1, RD_BASE+k, 8'h00}, where even k is the low byte and odd k is the high byte of channel k/2.
REQ-008 IDLE trigger: INT2=1 when poll_mode=0.
REQ-009 IDLE trigger: the poll counter equals poll_div when poll_mode=1; the counter clears on the trigger and is held at 0 while poll_mode=0.
REQ-010 On a trigger, the block SHALL issue transaction 0 in the same cycle and go to READ.
REQ-011 READ: on spi_done for transaction k, spi_rd[7:0] is stored in the shadow register byte k, and transaction k+1 is issued in the same cycle.
REQ-012 READ: on spi_done for the last transaction, the block stores the byte and goes to VALID with no write.
REQ-013 VALID (one cycle): shadow copies to data atomically, vld=1, then the block goes to IDLE; data never holds a partial frame.
REQ-014 Triggers during STARTUP, INIT, READ and VALID SHALL be ignored, not queued; if INT2 is still high in IDLE, a new frame starts immediately.
REQ-015 poll_div=0 SHALL be treated as 1.
REQ-016 At most one transaction SHALL be outstanding; spi_wrt is never asserted twice without an intervening spi_done, except the first write of a sequence.
REQ-017 spi_done in STARTUP or IDLE SHALL be ignored.

Reset
REQ-018 While rst_n=0, the block SHALL hold: state STARTUP, all counters 0, data=0, shadow=0, vld=0, spi_wrt=0, spi_cmd=0, tmo_err=0, busy=1.
REQ-019 Reset mid-frame SHALL abort with no vld pulse; the full startup and init sequence reruns.

Configuration
REQ-020 With IMU_TIMEOUT_EN defined, the block SHALL count cycles since the last spi_wrt in INIT or READ.
REQ-021 With IMU_TIMEOUT_EN defined, reaching TMO_CYC without spi_done SHALL set tmo_err and go to IDLE with no vld, discarding the shadow (init abort also goes to IDLE).
REQ-022 With IMU_TIMEOUT_EN defined, tmo_err SHALL clear on the next vld pulse.
REQ-023 With IMU_TIMEOUT_EN undefined, tmo_err SHALL be tied to 0, no timeout counter exists, and the block waits for spi_done indefinitely.

Verification
REQ-024 Startup/init: STARTUP_W=4, spi_done 20 cycles after each write -> first spi_wrt at cycle 15 with 16'h0D02, then 16'h1062, 16'h1162, 16'h1460, then busy=0.
REQ-025 INT frame: NUM_CH=5, INT high, spi_rd bytes 01..0A -> commands A200..AB00 in order; data[15:0]=16'h0201, data[79:64]=16'h0A09; one vld pulse.
REQ-026 Poll mode: poll_mode=1, poll_div=100, INT=0 -> frame starts every 100 cycles plus the frame length; no vld while poll_mode=0.
REQ-027 Trigger during READ: a second INT pulse mid-frame -> exactly one vld; data unchanged until VALID.
REQ-028 Timeout (IMU_TIMEOUT_EN, TMO_CYC=50): spi_done withheld on transaction 3 -> tmo_err=1 after 50 cycles, IDLE, data retains the old frame; the next good frame pulses vld and clears tmo_err.
REQ-029 Reset mid-READ: rst_n low for 2 cycles at transaction 4 -> outputs reach reset values asynchronously, no vld, and the init sequence repeats.
